// File: rtl/pipe_pkg.sv
// Shared definitions for the processor issue path: opcodes, NOP encoding,
// default pipeline depth and the requester tag carried alongside each issue.
package pipe_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  // ADD 0+0: harmless filler whose result nobody claims.
  localparam logic [7:0] NOP_INSTR = {OP_ADD, 6'b000_000};

  localparam int DEFAULT_PIPE_DEPTH = 4;
  localparam int TAG_ID_W           = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first asserted request at or above ptr,
// searching upward with wrap-around, wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  always_comb begin
    logic             found;
    logic [PTR_W:0]   idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N)) begin
        idx = idx - (PTR_W+1)'(N);
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// Shares one processor instruction port among NUM_REQ requesters and routes
// each result back to its issuer through a tag pipe matched to processor latency.
module issue_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter int         PIPE_DEPTH = pipe_pkg::DEFAULT_PIPE_DEPTH,
  parameter logic [7:0] NOP_INSTR  = pipe_pkg::NOP_INSTR
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*8-1:0]            req_instr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [7:0]                      proc_instr,
  input  logic [7:0]                      proc_res,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [7:0]                      resp_data,
  output logic [$clog2(PIPE_DEPTH+2)-1:0] in_flight
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PIPE_DEPTH+2);
  localparam int ID_W  = pipe_pkg::TAG_ID_W;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]          proc_instr_q, proc_instr_d;
  logic [CNT_W-1:0]    in_flight_q, in_flight_d;
  pipe_pkg::tag_t      tag_q [0:PIPE_DEPTH];
  pipe_pkg::tag_t      tag_d [0:PIPE_DEPTH];

  logic [NUM_REQ-1:0]  req_masked;
  logic [NUM_REQ-1:0]  grant;
  logic                accept;
  logic [PTR_W-1:0]    grant_id;
  logic [7:0]          grant_instr;
  logic                last_valid;

  // Flush blocks issue outright so a pending request simply waits.
  assign req_masked = req_valid & {NUM_REQ{~flush}};

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_masked),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign last_valid = tag_q[PIPE_DEPTH].valid;

  always_comb begin
    grant_id    = '0;
    grant_instr = NOP_INSTR;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id    = PTR_W'(i);
        grant_instr = req_instr[i*8 +: 8];
      end
    end
  end

  always_comb begin
    proc_instr_d = accept ? grant_instr : NOP_INSTR;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_id == PTR_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (flush) begin
      in_flight_d = '0;
    end else if (accept && !last_valid) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (!accept && last_valid) begin
      in_flight_d = in_flight_q - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= PIPE_DEPTH; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_d[gi] = '{valid: accept, id: ID_W'(grant_id)};
      end else begin : g_shift
        assign tag_d[gi] = flush ? '0 : tag_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_q[gi] <= '0;
        end else begin
          tag_q[gi] <= tag_d[gi];
        end
      end
    end

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      assign resp_valid[gi] = last_valid && (tag_q[PIPE_DEPTH].id == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      proc_instr_q <= NOP_INSTR;
      in_flight_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      proc_instr_q <= proc_instr_d;
      in_flight_q  <= in_flight_d;
    end
  end

  assign proc_instr = proc_instr_q;
  assign resp_data  = proc_res;
  assign in_flight  = in_flight_q;

endmodule

// File: tb/tb_issue_arbiter.sv
// Self-checking bench for issue_arbiter: a small processor stand-in plus a
// queue-based reference of issued-but-unanswered instructions.
module tb_issue_arbiter;

  localparam int N  = 4;
  localparam int PD = 4;
  localparam int CW = $clog2(PD+2);
  localparam logic [7:0] NOP = 8'h00;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*8-1:0]  req_instr = '0;
  logic [N-1:0]    req_ready;
  logic [7:0]      proc_instr;
  logic [7:0]      proc_res;
  logic [N-1:0]    resp_valid;
  logic [7:0]      resp_data;
  logic [CW-1:0]   in_flight;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  issue_arbiter #(.NUM_REQ(N), .PIPE_DEPTH(PD), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_instr  (req_instr),
    .req_ready  (req_ready),
    .proc_instr (proc_instr),
    .proc_res   (proc_res),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .in_flight  (in_flight)
  );

  function automatic logic [7:0] alu(input logic [7:0] ins);
    logic [7:0] a, b;
    a = {5'b0, ins[5:3]};
    b = {5'b0, ins[2:0]};
    case (ins[7:6])
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return b;
      default: return 8'h00;
    endcase
  endfunction

  // Processor stand-in: IF_ID, ID_EX, EX_WB stages then the res register.
  logic [7:0] pstage [0:PD-2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PD-1; i++) pstage[i] <= 8'h00;
      proc_res <= 8'h00;
    end else begin
      pstage[0] <= proc_instr;
      for (int i = 1; i < PD-1; i++) pstage[i] <= pstage[i-1];
      proc_res <= alu(pstage[PD-2]);
    end
  end

  // Reference: pending responses with the cycle they become visible.
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];
  int   cycle = 0;
  int   m_ptr = 0;

  logic [N-1:0] exp_ready, obs_ready, exp_resp_valid, obs_resp_valid;
  logic [7:0]   exp_proc_instr, obs_proc_instr, exp_resp_data, obs_resp_data;
  int           exp_inflight;
  logic [CW-1:0] obs_inflight;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] g;
    int best, bd, d;
    g = '0; best = -1; bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - ptr + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    if (best >= 0) g[best] = 1'b1;
    return g;
  endfunction

  // Advance one clock with the inputs already applied; records expected and observed values.
  task automatic step();
    int gid;
    logic [7:0] acc;
    exp_t e;
    #1;
    obs_ready = req_ready;
    exp_ready = flush ? '0 : model_grant(req_valid, m_ptr);
    gid = -1;
    acc = NOP;
    for (int i = 0; i < N; i++) if (exp_ready[i]) gid = i;
    if (gid >= 0) acc = req_instr[gid*8 +: 8];
    @(posedge clk);
    cycle++;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      exp_proc_instr = NOP;
    end else begin
      if (flush) q.delete();
      if (gid >= 0) begin
        e.due = cycle + PD; e.id = gid; e.data = alu(acc);
        q.push_back(e);
        m_ptr = (gid + 1) % N;
        exp_proc_instr = acc;
      end else begin
        exp_proc_instr = NOP;
      end
    end
    #1;
    while (q.size() > 0 && q[0].due < cycle) void'(q.pop_front());
    exp_resp_valid = '0;
    exp_resp_data  = 8'h00;
    exp_inflight   = q.size();
    if (q.size() > 0 && q[0].due == cycle) begin
      exp_resp_valid[q[0].id] = 1'b1;
      exp_resp_data = q[0].data;
    end
    obs_proc_instr = proc_instr;
    obs_resp_valid = resp_valid;
    obs_resp_data  = resp_data;
    obs_inflight   = in_flight;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0110;
    req_instr = 32'h1A1A1A1A;
    step();
    n_checks++;
    if (obs_ready !== 4'b0010) begin n_errors++; $display("FAIL reset_ready_follows: got %b want %b", obs_ready, 4'b0010); end
    n_checks++;
    if (obs_proc_instr !== NOP) begin n_errors++; $display("FAIL reset_proc_instr: got %h want %h", obs_proc_instr, NOP); end
    n_checks++;
    if (obs_resp_valid !== 4'b0000 || obs_inflight !== 3'd0) begin
      n_errors++; $display("FAIL reset_idle: resp_valid=%b in_flight=%0d want 0/0", obs_resp_valid, obs_inflight);
    end
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs_proc_instr !== NOP || obs_inflight !== 3'd0) begin
      n_errors++; $display("FAIL reset_release: proc_instr=%h in_flight=%0d want %h/0", obs_proc_instr, obs_inflight, NOP);
    end
  endtask

  task automatic test_single_issue();
    req_valid = 4'b0001;
    req_instr = 32'h0000001A;
    step();
    req_valid = '0;
    n_checks++;
    if (obs_proc_instr !== 8'h1A) begin n_errors++; $display("FAIL single_proc_instr: got %h want 1a", obs_proc_instr); end
    n_checks++;
    if (obs_inflight !== 3'd1) begin n_errors++; $display("FAIL single_inflight_up: got %0d want 1", obs_inflight); end
    for (int s = 1; s <= 5; s++) begin
      step();
      if (s == 4) begin
        n_checks++;
        if (obs_resp_valid !== 4'b0001 || obs_resp_data !== 8'h05) begin
          n_errors++; $display("FAIL single_resp: got %b/%h want 0001/05", obs_resp_valid, obs_resp_data);
        end
      end else begin
        n_checks++;
        if (obs_resp_valid !== 4'b0000) begin n_errors++; $display("FAIL single_no_resp s=%0d: got %b want 0000", s, obs_resp_valid); end
      end
    end
    n_checks++;
    if (obs_inflight !== 3'd0) begin n_errors++; $display("FAIL single_inflight_down: got %0d want 0", obs_inflight); end
  endtask

  task automatic test_arith();
    logic [7:0] ins [3];
    logic [7:0] want [3];
    int hits, first;
    ins[0] = 8'h53; ins[1] = 8'h87; ins[2] = 8'hFF;
    want[0] = 8'hFF; want[1] = 8'h07; want[2] = 8'h00;
    hits = 0; first = -1;
    for (int s = 0; s < 12; s++) begin
      req_valid = (s < 3) ? 4'b0010 : 4'b0000;
      if (s < 3) req_instr = {16'h0, ins[s], 8'h0};
      step();
      if (s < 3) begin
        n_checks++;
        if (obs_ready !== 4'b0010) begin n_errors++; $display("FAIL arith_ready s=%0d: got %b want 0010", s, obs_ready); end
      end
      if (obs_resp_valid[1]) begin
        if (first < 0) first = s;
        n_checks++;
        if (hits > 2 || s != first + hits || obs_resp_data !== want[hits > 2 ? 2 : hits]) begin
          n_errors++; $display("FAIL arith_resp s=%0d: got %h (pulse %0d)", s, obs_resp_data, hits);
        end
        hits++;
      end
    end
    n_checks++;
    if (hits != 3 || first != 4) begin n_errors++; $display("FAIL arith_count: got %0d pulses first at %0d want 3 at 4", hits, first); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    rst_n = 1'b0; req_valid = '0;
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 18; s++) begin
      req_valid = (s < 8) ? 4'b1111 : 4'b0000;
      req_instr = $urandom;
      step();
      if (s < 8) begin
        want = 4'b0001 << (s % 4);
        n_checks++;
        if (obs_ready !== want) begin n_errors++; $display("FAIL fair_grant s=%0d: got %b want %b", s, obs_ready, want); end
        n_checks++;
        if (obs_proc_instr !== exp_proc_instr) begin n_errors++; $display("FAIL fair_instr s=%0d: got %h want %h", s, obs_proc_instr, exp_proc_instr); end
      end
      want = (s >= 4 && s < 12) ? (4'b0001 << ((s - 4) % 4)) : 4'b0000;
      n_checks++;
      if (obs_resp_valid !== want) begin n_errors++; $display("FAIL fair_resp s=%0d: got %b want %b", s, obs_resp_valid, want); end
      if (want != 0) begin
        n_checks++;
        if (obs_resp_data !== exp_resp_data) begin n_errors++; $display("FAIL fair_data s=%0d: got %h want %h", s, obs_resp_data, exp_resp_data); end
      end
    end
  endtask

  task automatic test_idle_gaps();
    int pulses, last_s, gap;
    pulses = 0; last_s = -1; gap = -1;
    for (int s = 0; s < 14; s++) begin
      req_valid = (s == 0 || s == 4) ? 4'b0100 : 4'b0000;
      req_instr = {8'h0, 8'h1A + 8'(s), 16'h0};
      step();
      if (s >= 1 && s <= 3) begin
        n_checks++;
        if (obs_proc_instr !== 8'h00) begin n_errors++; $display("FAIL gap_nop s=%0d: got %h want 00", s, obs_proc_instr); end
      end
      if (obs_resp_valid[2]) begin
        if (last_s >= 0) gap = s - last_s;
        last_s = s; pulses++;
      end
      n_checks++;
      if (obs_resp_valid !== exp_resp_valid) begin n_errors++; $display("FAIL gap_resp s=%0d: got %b want %b", s, obs_resp_valid, exp_resp_valid); end
    end
    n_checks++;
    if (pulses != 2 || gap != 4) begin n_errors++; $display("FAIL gap_pulses: got %0d pulses gap %0d want 2 gap 4", pulses, gap); end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    req_instr = 32'h13_12_11_1A;
    for (int s = 0; s < 14; s++) begin
      flush = (s == 4);
      case (s)
        0: req_valid = 4'b0001;
        1: req_valid = 4'b0010;
        2: req_valid = 4'b0100;
        4, 5: req_valid = 4'b0001;
        default: req_valid = 4'b0000;
      endcase
      step();
      if (s == 4) begin
        n_checks++;
        if (obs_ready !== 4'b0000) begin n_errors++; $display("FAIL flush_ready: got %b want 0000", obs_ready); end
        n_checks++;
        if (obs_inflight !== 3'd0 || obs_proc_instr !== NOP) begin
          n_errors++; $display("FAIL flush_state: in_flight=%0d proc_instr=%h want 0/%h", obs_inflight, obs_proc_instr, NOP);
        end
      end
      if (s == 5) begin
        n_checks++;
        if (obs_ready !== 4'b0001) begin n_errors++; $display("FAIL flush_retry: got %b want 0001", obs_ready); end
      end
      if (obs_resp_valid != 0) pulses++;
      n_checks++;
      if (obs_resp_valid !== exp_resp_valid) begin n_errors++; $display("FAIL flush_resp s=%0d: got %b want %b", s, obs_resp_valid, exp_resp_valid); end
    end
    flush = 1'b0;
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL flush_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    req_instr = 32'h44_33_22_11;
    for (int s = 0; s < 3; s++) begin
      req_valid = 4'b0001 << s;
      step();
    end
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_ptr = 0;
    n_checks++;
    if (in_flight !== 3'd0 || resp_valid !== 4'b0000 || proc_instr !== NOP) begin
      n_errors++; $display("FAIL mreset_async: in_flight=%0d resp_valid=%b proc_instr=%h want 0/0000/%h", in_flight, resp_valid, proc_instr, NOP);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 10; s++) begin
      req_valid = (s < 2) ? 4'b1001 : 4'b0000;
      if (s == 1) req_valid = 4'b1000;
      step();
      if (s == 0) begin
        n_checks++;
        if (obs_ready !== 4'b0001) begin n_errors++; $display("FAIL mreset_first: got %b want 0001", obs_ready); end
      end
      if (s == 1) begin
        n_checks++;
        if (obs_ready !== 4'b1000) begin n_errors++; $display("FAIL mreset_second: got %b want 1000", obs_ready); end
      end
      if (obs_resp_valid != 0) pulses++;
      n_checks++;
      if (obs_resp_valid !== exp_resp_valid) begin n_errors++; $display("FAIL mreset_resp s=%0d: got %b want %b", s, obs_resp_valid, exp_resp_valid); end
    end
    n_checks++;
    if (pulses != 2) begin n_errors++; $display("FAIL mreset_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      req_valid = N'($urandom);
      req_instr = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      step();
      n_checks++;
      if (obs_ready !== exp_ready) begin n_errors++; $display("FAIL rand_ready s=%0d: got %b want %b", s, obs_ready, exp_ready); end
      n_checks++;
      if (obs_proc_instr !== exp_proc_instr) begin n_errors++; $display("FAIL rand_instr s=%0d: got %h want %h", s, obs_proc_instr, exp_proc_instr); end
      n_checks++;
      if (obs_resp_valid !== exp_resp_valid) begin n_errors++; $display("FAIL rand_resp s=%0d: got %b want %b", s, obs_resp_valid, exp_resp_valid); end
      if (exp_resp_valid != 0) begin
        n_checks++;
        if (obs_resp_data !== exp_resp_data) begin n_errors++; $display("FAIL rand_data s=%0d: got %h want %h", s, obs_resp_data, exp_resp_data); end
      end
      n_checks++;
      if (obs_inflight !== CW'(exp_inflight)) begin n_errors++; $display("FAIL rand_inflight s=%0d: got %0d want %0d", s, obs_inflight, exp_inflight); end
    end
    flush = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_arith();
    test_fairness();
    test_idle_gaps();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
